// File: rtl/clk_rst_pkg.sv
// Shared clock/reset types: sequencer state encoding, default timing constants, helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } seq_state_t;

    localparam int DEF_NUM_CH              = 2;
    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_STAGGER_CYCLES      = 8;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
// Latency: 2 clk cycles from a stable input to q.
// Backpressure: none; the level is sampled every cycle.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse, lock qualification with timeout retry, staggered channel reset release.
// Latency: 2-cycle lock synchroniser, then registered outputs one edge after each decision.
// Backpressure: none; relock_req is a single-cycle pulse, ignored while the PLL is in reset.
module pll_reset_sequencer
    import clk_rst_pkg::*;
#(
    parameter int NUM_CH              = DEF_NUM_CH,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int STAGGER_CYCLES      = DEF_STAGGER_CYCLES
) (
    input  logic              clkin,
    input  logic              resetn,
    input  logic              pll_locked,
    input  logic              relock_req,
    output logic              pll_rst,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              ready,
    output logic [7:0]        lock_loss_cnt,
    output logic [7:0]        retry_cnt
);

    localparam int REL_SPAN = STAGGER_CYCLES * (NUM_CH - 1);
    localparam int MAX_CYC  = max_of(max_of(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                     max_of(LOCK_TIMEOUT_CYCLES, max_of(STAGGER_CYCLES, REL_SPAN)));
    localparam int CW       = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock counts toward the stable run.
    localparam logic [CW-1:0] STB_LAST = CW'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [CW-1:0] REL_LAST = CW'(REL_SPAN);

    logic lk;

    seq_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pll_rst_q, pll_rst_d;
    logic [NUM_CH-1:0] ch_rst_n_q, ch_rst_n_d;
    logic              ready_q, ready_d;
    logic [7:0]        loss_q, loss_d;
    logic [7:0]        retry_q, retry_d;

    sync_2ff u_lock_sync (
        .clk   (clkin),
        .rst_n (resetn),
        .d     (pll_locked),
        .q     (lk)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        loss_d  = loss_q;
        retry_d = retry_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (relock_req) begin
                    state_d = PLL_RST;
                end else if (lk) begin
                    state_d = (LOCK_STABLE_CYCLES == 1) ? RELEASE : STABLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = PLL_RST;
                    retry_d = sat_inc8(retry_q);
                end
            end
            STABLE: begin
                if (relock_req)            state_d = PLL_RST;
                else if (!lk)              state_d = WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = RELEASE;
            end
            RELEASE: begin
                if (!lk || relock_req)     state_d = PLL_RST;
                else if (cnt_q == REL_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q;
                if (!lk) begin
                    state_d = PLL_RST;
                    loss_d  = sat_inc8(loss_q);
                end else if (relock_req) begin
                    state_d = PLL_RST;
                end
            end
            default: state_d = PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so they update on the same edge as the FSM.
    always_comb begin
        pll_rst_d  = (state_d == PLL_RST);
        ready_d    = (state_d == RUN);
        ch_rst_n_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_rst_n_d[i] = (state_d == RUN) ||
                            ((state_d == RELEASE) && (cnt_d >= CW'(i * STAGGER_CYCLES)));
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q    <= PLL_RST;
            cnt_q      <= '0;
            pll_rst_q  <= 1'b1;
            ch_rst_n_q <= '0;
            ready_q    <= 1'b0;
            loss_q     <= 8'd0;
            retry_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pll_rst_q  <= pll_rst_d;
            ch_rst_n_q <= ch_rst_n_d;
            ready_q    <= ready_d;
            loss_q     <= loss_d;
            retry_q    <= retry_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign ch_rst_n      = ch_rst_n_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;
    assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: release-timing vector table plus hand-built corner sequences,
// checked through a cycle-stamped expectation queue.
module tb_pll_reset_sequencer;

    localparam int NCH = 3;

    logic           clkin = 1'b0;
    logic           resetn;
    logic           pll_locked;
    logic           relock_req;
    logic           pll_rst;
    logic [NCH-1:0] ch_rst_n;
    logic           ready;
    logic [7:0]     lock_loss_cnt;
    logic [7:0]     retry_cnt;

    pll_reset_sequencer #(
        .NUM_CH              (NCH),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (10),
        .LOCK_TIMEOUT_CYCLES (50),
        .STAGGER_CYCLES      (3)
    ) dut (
        .clkin         (clkin),
        .resetn        (resetn),
        .pll_locked    (pll_locked),
        .relock_req    (relock_req),
        .pll_rst       (pll_rst),
        .ch_rst_n      (ch_rst_n),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .retry_cnt     (retry_cnt)
    );

    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct {
        int         off;
        logic [2:0] ch;
        logic       rdy;
        logic       prst;
    } vec_t;

    typedef struct {
        string      name;
        int         cyc;
        logic [2:0] ch;
        logic       rdy;
        logic       prst;
        logic [7:0] lcnt;
        logic [7:0] rcnt;
    } exp_t;

    vec_t rel_tbl[8];
    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   exp_loss  = 0;
    int   exp_retry = 0;

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic logic cur_sig(input int sel);
        return (sel == 0) ? pll_rst : ready;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input string name, input int c, input logic [2:0] ch, input logic rdy,
                        input logic prst, input int lc, input int rc);
        exp_t e;
        e.name = name;
        e.cyc  = c;
        e.ch   = ch;
        e.rdy  = rdy;
        e.prst = prst;
        e.lcnt = 8'(lc);
        e.rcnt = 8'(rc);
        sb.push_back(e);
    endtask

    task automatic service();
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || ch_rst_n !== e.ch || ready !== e.rdy || pll_rst !== e.prst ||
                lock_loss_cnt !== e.lcnt || retry_cnt !== e.rcnt) begin
                errors++;
                $display("FAIL %s @cyc %0d (due %0d): got ch=%b rdy=%b prst=%b loss=%0d retry=%0d, expected ch=%b rdy=%b prst=%b loss=%0d retry=%0d",
                         e.name, cyc, e.cyc, ch_rst_n, ready, pll_rst, lock_loss_cnt, retry_cnt,
                         e.ch, e.rdy, e.prst, e.lcnt, e.rcnt);
            end
        end
    endtask

    task automatic tick();
        @(negedge clkin);
        service();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected records never reached, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_level(input string name, input int sel, input logic val, input int budget);
        int n = 0;
        while (cur_sig(sel) !== val && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (cur_sig(sel) !== val) begin
            errors++;
            $display("FAIL %s: level %b after %0d cycles, required %b", name, cur_sig(sel), budget, val);
        end
    endtask

    task automatic lock_and_release();
        int l;
        wait_level("pll_rst_fall", 0, 1'b0, 200);
        pll_locked = 1'b1;
        l = cyc;
        foreach (rel_tbl[i])
            push($sformatf("release[%0d]", i), l + rel_tbl[i].off, rel_tbl[i].ch, rel_tbl[i].rdy,
                 rel_tbl[i].prst, exp_loss, exp_retry);
        drain(40);
    endtask

    task automatic drop_in_run();
        int d = cyc;
        pll_locked = 1'b0;
        push("loss_hold", d + 2, 3'b111, 1'b1, 1'b0, exp_loss, exp_retry);
        exp_loss = sat(exp_loss);
        push("loss_reset", d + 3, 3'b000, 1'b0, 1'b1, exp_loss, exp_retry);
        drain(10);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int l;
        int d;

        // Offsets are cycles after the raw lock rises while in WAIT_LOCK.
        rel_tbl[0] = '{1,  3'b000, 1'b0, 1'b0};
        rel_tbl[1] = '{11, 3'b000, 1'b0, 1'b0};
        rel_tbl[2] = '{12, 3'b001, 1'b0, 1'b0};
        rel_tbl[3] = '{14, 3'b001, 1'b0, 1'b0};
        rel_tbl[4] = '{15, 3'b011, 1'b0, 1'b0};
        rel_tbl[5] = '{17, 3'b011, 1'b0, 1'b0};
        rel_tbl[6] = '{18, 3'b111, 1'b0, 1'b0};
        rel_tbl[7] = '{19, 3'b111, 1'b1, 1'b0};

        resetn     = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) tick();
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_ch", int'(ch_rst_n), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_loss", int'(lock_loss_cnt), 0);
        chk("rst_retry", int'(retry_cnt), 0);

        resetn = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("pll_rst_width", n, 4);

        lock_and_release();
        drop_in_run();
        lock_and_release();

        // Lock never returns: PLL reset re-pulses every 4+50 cycles.
        d = cyc;
        pll_locked = 1'b0;
        push("retry_hold", d + 2, 3'b111, 1'b1, 1'b0, exp_loss, exp_retry);
        exp_loss = sat(exp_loss);
        push("retry_loss", d + 3, 3'b000, 1'b0, 1'b1, exp_loss, exp_retry);
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("retry%0d_low", k), d + 3 + 54 * k - 1, 3'b000, 1'b0, 1'b0, exp_loss, exp_retry);
            exp_retry = sat(exp_retry);
            push($sformatf("retry%0d_pulse", k), d + 3 + 54 * k, 3'b000, 1'b0, 1'b1, exp_loss, exp_retry);
        end
        drain(200);

        // Relock with only channel 0 out of reset, then a relock inside the PLL pulse.
        wait_level("pll_rst_fall", 0, 1'b0, 200);
        l = cyc;
        pll_locked = 1'b1;
        push("rlk_ch0", l + 12, 3'b001, 1'b0, 1'b0, exp_loss, exp_retry);
        push("rlk_hold", l + 13, 3'b001, 1'b0, 1'b0, exp_loss, exp_retry);
        push("rlk_reset", l + 14, 3'b000, 1'b0, 1'b1, exp_loss, exp_retry);
        push("rlk_ignored", l + 17, 3'b000, 1'b0, 1'b1, exp_loss, exp_retry);
        push("rlk_fall", l + 18, 3'b000, 1'b0, 1'b0, exp_loss, exp_retry);
        push("rlk_stable", l + 27, 3'b000, 1'b0, 1'b0, exp_loss, exp_retry);
        push("rlk_rel", l + 28, 3'b001, 1'b0, 1'b0, exp_loss, exp_retry);
        push("rlk_run", l + 35, 3'b111, 1'b1, 1'b0, exp_loss, exp_retry);
        while (sb.size() > 0 && cyc < l + 40) begin
            tick();
            relock_req = (cyc == l + 13) || (cyc == l + 15);
        end
        relock_req = 1'b0;
        drain(5);

        // Two-cycle lock glitch while the stable count is at 7.
        drop_in_run();
        wait_level("pll_rst_fall", 0, 1'b0, 200);
        l = cyc;
        pll_locked = 1'b1;
        push("glitch_none12", l + 12, 3'b000, 1'b0, 1'b0, exp_loss, exp_retry);
        push("glitch_none21", l + 21, 3'b000, 1'b0, 1'b0, exp_loss, exp_retry);
        push("glitch_rel", l + 22, 3'b001, 1'b0, 1'b0, exp_loss, exp_retry);
        push("glitch_run", l + 29, 3'b111, 1'b1, 1'b0, exp_loss, exp_retry);
        while (sb.size() > 0 && cyc < l + 40) begin
            tick();
            if (cyc == l + 8)  pll_locked = 1'b0;
            if (cyc == l + 10) pll_locked = 1'b1;
        end
        drain(5);

        // Relock request and lock loss land in the same RUN cycle.
        d = cyc;
        pll_locked = 1'b0;
        push("both_hold", d + 2, 3'b111, 1'b1, 1'b0, exp_loss, exp_retry);
        exp_loss = sat(exp_loss);
        push("both_reset", d + 3, 3'b000, 1'b0, 1'b1, exp_loss, exp_retry);
        push("both_pulse", d + 6, 3'b000, 1'b0, 1'b1, exp_loss, exp_retry);
        push("both_fall", d + 7, 3'b000, 1'b0, 1'b0, exp_loss, exp_retry);
        while (sb.size() > 0 && cyc < d + 20) begin
            tick();
            relock_req = (cyc == d + 2);
        end
        relock_req = 1'b0;
        drain(5);

        // Asynchronous reset in the middle of the stagger.
        l = cyc;
        pll_locked = 1'b1;
        push("arst_ch1", l + 16, 3'b011, 1'b0, 1'b0, exp_loss, exp_retry);
        drain(30);
        resetn = 1'b0;
        #1;
        chk("arst_ch", int'(ch_rst_n), 0);
        chk("arst_ready", int'(ready), 0);
        chk("arst_pll_rst", int'(pll_rst), 1);
        chk("arst_loss", int'(lock_loss_cnt), 0);
        chk("arst_retry", int'(retry_cnt), 0);
        exp_loss  = 0;
        exp_retry = 0;
        tick();
        pll_locked = 1'b0;
        tick();
        resetn = 1'b1;

        for (int i = 0; i < 300; i++) begin
            lock_and_release();
            drop_in_run();
        end
        chk("loss_saturated", int'(lock_loss_cnt), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 2, number of sequenced reset channels (1..8); channel 0 released first.
REQ-002 Parameter PLL_RST_CYCLES, default 16, clkin cycles pll_rst held high per PLL reset pulse (>=1).
REQ-003 Parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronised-lock cycles required before release (>=1).
REQ-004 Parameter LOCK_TIMEOUT_CYCLES, default 65536, cycles in WAIT_LOCK before a PLL reset retry (> LOCK_STABLE_CYCLES).
REQ-005 Parameter STAGGER_CYCLES, default 8, cycles between successive channel releases (>=1).
REQ-006 clkin  input  1  reference clock; all logic in this domain, rising edge.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 pll_locked  input  1  raw PLL LOCK, asynchronous to clkin.
REQ-009 relock_req  input  1  single-cycle pulse requesting a full PLL re-lock.
REQ-010 pll_rst  output  1  active-high PLL RST drive.
REQ-011 ch_rst_n  output  NUM_CH  per-channel active-low reset, registered.
REQ-012 ready  output  1  high only when all channels released and lock held.
REQ-013 lock_loss_cnt  output  8  saturating count of lock losses after ready.
REQ-014 retry_cnt  output  8  saturating count of WAIT_LOCK timeouts.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchroniser; all decisions use the synchronised lock (lk), adding 2 cycles latency.
REQ-016 FSM states SHALL be PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN.
REQ-017 PLL_RST: pll_rst=1, all ch_rst_n=0; after PLL_RST_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0; lk=1 -> STABLE (counter cleared); counter reaching LOCK_TIMEOUT_CYCLES -> PLL_RST, retry_cnt+1.
REQ-019 STABLE: counter increments while lk=1; lk=0 -> WAIT_LOCK with timeout counter cleared; count reaches LOCK_STABLE_CYCLES -> RELEASE.
REQ-020 RELEASE: ch_rst_n[0] SHALL rise on the first RELEASE cycle, each ch_rst_n[i] STAGGER_CYCLES after ch_rst_n[i-1]; after the last channel -> RUN next cycle.
REQ-021 RUN: ready=1, all ch_rst_n=1.
REQ-022 lk=0 in RELEASE or RUN SHALL, on the next edge, drive all ch_rst_n=0, ready=0, enter PLL_RST; lock_loss_cnt+1 only if the loss occurred in RUN.
REQ-023 relock_req=1 in any state except PLL_RST SHALL enter PLL_RST next cycle with all ch_rst_n=0; counters unchanged.
REQ-024 relock_req and lk=0 in the same RUN cycle: PLL_RST entered once, lock_loss_cnt incremented once.
REQ-025 relock_req during PLL_RST SHALL be ignored (no extension of pulse).
REQ-026 lock_loss_cnt and retry_cnt SHALL saturate at 255, never wrap.
REQ-027 Cycle counter width SHALL be $clog2 of the largest cycle parameter plus 1; one shared counter cleared on every state change.
REQ-028 All outputs SHALL be registered; no combinational path input->output.

Reset
REQ-029 resetn=0 SHALL asynchronously force: state PLL_RST, pll_rst=1, ch_rst_n=all 0, ready=0, counters and synchroniser 0.
REQ-030 Reset deassertion SHALL be used synchronously; first post-reset cycle begins a full PLL_RST_CYCLES pulse.
REQ-031 resetn assertion mid-RELEASE or mid-RUN SHALL immediately drop all channel resets regardless of stagger position.

Structure
REQ-032 State encoding enum and default parameter constants SHALL reside in shared package clk_rst_pkg.
REQ-033 The 2-flop synchroniser SHALL be sub-module sync_2ff (reused by downstream domains for ch_rst_n).
REQ-034 Downstream clock domains SHALL resynchronise ch_rst_n through sync_2ff; this block does not.

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=10, STAGGER_CYCLES=3, LOCK_TIMEOUT_CYCLES=50, NUM_CH=3)
REQ-035 Release resetn, assert pll_locked after pll_rst falls -> pll_rst high exactly 4 cycles; ch_rst_n[0] rises 2+10 cycles after lock; [1],[2] +3,+6 cycles; ready 1 cycle after [2].
REQ-036 Hold pll_locked=0 -> pll_rst re-pulses every 54 cycles; retry_cnt 1,2,3...
REQ-037 Glitch pll_locked low 2 cycles during STABLE at count 7 -> return to WAIT_LOCK, stable count restarts, no channel released.
REQ-038 Drop pll_locked in RUN -> all ch_rst_n=0 and ready=0 within 3 cycles of raw drop; lock_loss_cnt=1; full sequence repeats.
REQ-039 Pulse relock_req mid-RELEASE with only ch 0 released -> all channels reset next cycle; lock_loss_cnt unchanged.
REQ-040 Force 300 lock losses -> lock_loss_cnt holds 255.
